// File: rtl/ground_anim_pkg.sv
// Shared types and constants for the ground-tile animation sequencer.
// Holds the channel state encoding, play modes and the hold-field decoder.
package ground_anim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    localparam bit MODE_ONESHOT = 1'b0;
    localparam bit MODE_LOOP    = 1'b1;

    localparam int HOLD_VEC_MAX = 256;

    // Last hold_cnt value for one frame; a zero field behaves like a one-tick hold.
    function automatic int unsigned hold_last(input logic [HOLD_VEC_MAX-1:0] hold,
                                              input int unsigned hold_w,
                                              input int unsigned frame);
        int unsigned field;
        int unsigned idx;
        field = 0;
        for (int b = 0; b < 32; b++) begin
            idx = frame * hold_w + b;
            if (b < hold_w && idx < HOLD_VEC_MAX) field[b] = hold[idx];
        end
        return (field == 0) ? 0 : field - 1;
    endfunction

endpackage

// File: rtl/ground_anim_seq_if.sv
// Trigger / ROM / pixel bundle between the ground ROM cores, the sequencer
// and the VGA colour mux.
interface ground_anim_seq_if #(
    parameter int NCH    = 3,
    parameter int NFRAME = 4,
    parameter int PIX_W  = 12
);
    localparam int FW = $clog2(NFRAME);

    logic [NCH-1:0]              trig;
    logic [NCH-1:0]              rearm;
    logic [NCH*NFRAME*PIX_W-1:0] rom_pix;
    logic [NCH*PIX_W-1:0]        vga_pix;
    logic [NCH*FW-1:0]           frame_idx;
    logic [NCH-1:0]              busy;
    logic [NCH-1:0]              done;

    modport master (output trig, rearm, rom_pix,
                    input  vga_pix, frame_idx, busy, done);
    modport slave  (input  trig, rearm, rom_pix,
                    output vga_pix, frame_idx, busy, done);

endinterface

// File: rtl/ground_anim_ch.sv
// One animation channel: state machine, per-frame hold counter, frame index
// and the registered pixel select among this channel's ROM words.
module ground_anim_ch
    import ground_anim_pkg::*;
#(
    parameter int                       NFRAME = 4,
    parameter int                       PIX_W  = 12,
    parameter int                       HOLD_W = 8,
    parameter logic [NFRAME*HOLD_W-1:0] HOLD   = {8'd1, 8'd4, 8'd3, 8'd15},
    parameter bit                       LOOP   = MODE_ONESHOT,
    parameter int                       FW     = $clog2(NFRAME)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    trig,
    input  logic                    rearm,
    input  logic [NFRAME*PIX_W-1:0] rom_words,
    output logic [PIX_W-1:0]        pix,
    output logic [FW-1:0]           frame,
    output logic                    busy,
    output logic                    done
);

    localparam logic [FW-1:0] FRAME_LAST   = FW'(NFRAME - 1);
    localparam logic [FW-1:0] FRAME_PENULT = FW'(NFRAME - 2);

    ch_state_e          state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  last_hold [NFRAME];

    for (genvar f = 0; f < NFRAME; f++) begin : g_hold
        localparam int unsigned LAST = hold_last(HOLD_VEC_MAX'(HOLD), HOLD_W, f);
        assign last_hold[f] = HOLD_W'(LAST);
    end

    // NOTE: every register here is assigned with <= so all channels and the
    // pixel register see the same pre-edge frame value; blocking would race.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            frame    <= '0;
            hold_cnt <= '0;
            pix      <= '0;
        end else begin
            pix <= rom_words[frame*PIX_W +: PIX_W];
            if (rearm) begin
                state    <= ST_IDLE;
                frame    <= '0;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        frame <= '0;
                        if (trig) begin
                            state    <= ST_RUN;
                            hold_cnt <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            if (hold_cnt == last_hold[frame]) begin
                                hold_cnt <= '0;
                                // Only reachable in loop mode: one-shot stops before running frame LAST.
                                if (frame == FRAME_LAST) begin
                                    frame <= '0;
                                    if (!trig) state <= ST_IDLE;
                                end else begin
                                    frame <= frame + 1'b1;
                                    if (LOOP == MODE_ONESHOT && frame == FRAME_PENULT)
                                        state <= ST_DONE;
                                end
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DONE: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: rtl/ground_anim_seq.sv
// Multi-channel ground-tile animation sequencer: shared animation-tick
// prescaler feeding NCH independent channel sequencers.
module ground_anim_seq
    import ground_anim_pkg::*;
#(
    parameter int                       NCH      = 3,
    parameter int                       NFRAME   = 4,
    parameter int                       PIX_W    = 12,
    parameter int                       TICK_DIV = 6000000,
    parameter int                       HOLD_W   = 8,
    parameter logic [NFRAME*HOLD_W-1:0] HOLD     = {8'd1, 8'd4, 8'd3, 8'd15},
    parameter bit                       LOOP     = MODE_ONESHOT
) (
    input logic               clk,
    input logic               rst_n,
    ground_anim_seq_if.slave  bus
);

    localparam int FW = $clog2(NFRAME);
    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    logic [NCH-1:0][PIX_W-1:0] pix_arr;
    logic [NCH-1:0][FW-1:0]    frame_arr;
    logic [NCH-1:0]            busy_vec;
    logic [NCH-1:0]            done_vec;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ground_anim_ch #(
            .NFRAME (NFRAME),
            .PIX_W  (PIX_W),
            .HOLD_W (HOLD_W),
            .HOLD   (HOLD),
            .LOOP   (LOOP),
            .FW     (FW)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .trig      (bus.trig[i]),
            .rearm     (bus.rearm[i]),
            .rom_words (bus.rom_pix[i*NFRAME*PIX_W +: NFRAME*PIX_W]),
            .pix       (pix_arr[i]),
            .frame     (frame_arr[i]),
            .busy      (busy_vec[i]),
            .done      (done_vec[i])
        );
    end

    assign bus.vga_pix   = pix_arr;
    assign bus.frame_idx = frame_arr;
    assign bus.busy      = busy_vec;
    assign bus.done      = done_vec;

endmodule

// File: tb/tb_ground_anim_seq.sv
// Self-checking bench: a one-shot and a looping instance driven side by side
// and compared every cycle against a tick-count schedule model.
module tb_ground_anim_seq;

    localparam int NCH      = 3;
    localparam int NFRAME   = 4;
    localparam int PIX_W    = 12;
    localparam int TICK_DIV = 4;
    localparam int HOLD_W   = 8;
    localparam int FW       = $clog2(NFRAME);
    localparam logic [NFRAME*HOLD_W-1:0] HOLD = {8'd1, 8'd4, 8'd3, 8'd15};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ground_anim_seq_if #(.NCH(NCH), .NFRAME(NFRAME), .PIX_W(PIX_W)) os_if ();
    ground_anim_seq_if #(.NCH(NCH), .NFRAME(NFRAME), .PIX_W(PIX_W)) lp_if ();

    ground_anim_seq #(.NCH(NCH), .NFRAME(NFRAME), .PIX_W(PIX_W), .TICK_DIV(TICK_DIV),
                      .HOLD_W(HOLD_W), .HOLD(HOLD), .LOOP(1'b0))
        dut_os (.clk(clk), .rst_n(rst_n), .bus(os_if));

    ground_anim_seq #(.NCH(NCH), .NFRAME(NFRAME), .PIX_W(PIX_W), .TICK_DIV(TICK_DIV),
                      .HOLD_W(HOLD_W), .HOLD(HOLD), .LOOP(1'b1))
        dut_lp (.clk(clk), .rst_n(rst_n), .bus(lp_if));

    int n_checks = 0;
    int n_fail   = 0;

    // Model: channel mode (0 idle, 1 run, 2 done) and ticks elapsed in the sequence.
    int              cum [NFRAME];
    int              period;
    int              m_st [2][NCH];
    int              m_e  [2][NCH];
    logic [PIX_W-1:0] m_pix [2][NCH];
    int              ncyc    = 0;
    bit              last_tk = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_of(input int e);
        int f = 0;
        for (int k = 0; k < NFRAME - 1; k++)
            if (e >= cum[k]) f = k + 1;
        return f;
    endfunction

    function automatic logic [PIX_W-1:0] word(input int i, input int f);
        return {4'(i), 4'(f), 4'hA};
    endfunction

    task automatic model_edge(input int d, input logic [NCH-1:0] tr, input logic [NCH-1:0] rr,
                              input logic [NCH*NFRAME*PIX_W-1:0] rom, input bit tk);
        for (int i = 0; i < NCH; i++) begin
            if (!rst_n) begin
                m_st[d][i]  = 0;
                m_e[d][i]   = 0;
                m_pix[d][i] = '0;
            end else begin
                m_pix[d][i] = rom[(i*NFRAME + frame_of(m_e[d][i]))*PIX_W +: PIX_W];
                if (rr[i]) begin
                    m_st[d][i] = 0;
                    m_e[d][i]  = 0;
                end else if (m_st[d][i] == 0) begin
                    if (tr[i]) begin
                        m_st[d][i] = 1;
                        m_e[d][i]  = 0;
                    end
                end else if (m_st[d][i] == 1 && tk) begin
                    m_e[d][i]++;
                    if (d == 0 && m_e[d][i] == cum[NFRAME-2]) begin
                        m_st[d][i] = 2;
                    end else if (d == 1 && m_e[d][i] == period) begin
                        m_e[d][i] = 0;
                        if (!tr[i]) m_st[d][i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        logic [NCH*FW-1:0]    ef;
        logic [NCH-1:0]       eb;
        logic [NCH-1:0]       ed;
        logic [NCH*PIX_W-1:0] ep;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NCH; i++) begin
                ef[i*FW +: FW]       = FW'(frame_of(m_e[d][i]));
                eb[i]                = (m_st[d][i] == 1);
                ed[i]                = (m_st[d][i] == 2);
                ep[i*PIX_W +: PIX_W] = m_pix[d][i];
            end
            if (d == 0) begin
                check("os_frame", 64'(os_if.frame_idx), 64'(ef));
                check("os_busy",  64'(os_if.busy),      64'(eb));
                check("os_done",  64'(os_if.done),      64'(ed));
                check("os_pix",   64'(os_if.vga_pix),   64'(ep));
            end else begin
                check("lp_frame", 64'(lp_if.frame_idx), 64'(ef));
                check("lp_busy",  64'(lp_if.busy),      64'(eb));
                check("lp_done",  64'(lp_if.done),      64'(ed));
                check("lp_pix",   64'(lp_if.vga_pix),   64'(ep));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        last_tk = rst_n && ((ncyc % TICK_DIV) == TICK_DIV - 1);
        model_edge(0, os_if.trig, os_if.rearm, os_if.rom_pix, last_tk);
        model_edge(1, lp_if.trig, lp_if.rearm, lp_if.rom_pix, last_tk);
        if (!rst_n) ncyc = 0;
        else        ncyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic wait_model(input int d, input int ch, input int f, input int st, input int budget);
        int n = 0;
        while (!(frame_of(m_e[d][ch]) == f && m_st[d][ch] == st)) begin
            if (n >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_timeout dut=%0d ch=%0d got_frame=%0d req_frame=%0d", d, ch,
                         frame_of(m_e[d][ch]), f);
                return;
            end
            cycle();
            n++;
        end
    endtask

    task automatic pulse_os_trig(input int ch);
        os_if.trig[ch] = 1'b1;
        cycle();
        os_if.trig[ch] = 1'b0;
    endtask

    task automatic pulse_os_rearm(input logic [NCH-1:0] m);
        os_if.rearm = m;
        cycle();
        os_if.rearm = '0;
    endtask

    initial begin
        logic [NFRAME*HOLD_W-1:0] hv;
        int run;
        int h;
        int n;
        int guard;
        int slot;

        hv  = HOLD;
        run = 0;
        for (int f = 0; f < NFRAME; f++) begin
            h = int'(hv[f*HOLD_W +: HOLD_W]);
            if (h == 0) h = 1;
            run   += h;
            cum[f] = run;
        end
        period = run;

        os_if.trig = '0; os_if.rearm = '0;
        lp_if.trig = '0; lp_if.rearm = '0;
        for (int i = 0; i < NCH; i++)
            for (int f = 0; f < NFRAME; f++) begin
                os_if.rom_pix[(i*NFRAME + f)*PIX_W +: PIX_W] = word(i, f);
                lp_if.rom_pix[(i*NFRAME + f)*PIX_W +: PIX_W] = word(i, f);
            end

        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Reset in the middle of a running sequence.
        pulse_os_trig(0);
        wait_model(0, 0, 1, 1, 200);
        check("mid_run_busy", 64'(os_if.busy[0]), 64'd1);
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        check("rst_frame", 64'(os_if.frame_idx), 64'd0);
        check("rst_busy",  64'(os_if.busy),      64'd0);
        check("rst_done",  64'(os_if.done),      64'd0);
        check("rst_pix",   64'(os_if.vga_pix),   64'd0);

        // One-shot sequence on channel 0, then held in DONE.
        pulse_os_trig(0);
        wait_model(0, 0, 3, 2, 400);
        check("os_done0", 64'(os_if.done[0]), 64'd1);
        cycle();
        check("os_pix_f3", 64'(os_if.vga_pix[PIX_W-1:0]), 64'h03A);
        repeat (100 * TICK_DIV) cycle();
        check("os_hold_frames", 64'(os_if.frame_idx), 64'h03);
        check("os_hold_done",   64'(os_if.done),      64'h1);

        // Rearm out of DONE, rearm mid-run, then trig+rearm together.
        pulse_os_rearm(3'b001);
        check("rearm_from_done", 64'(os_if.done[0]), 64'd0);
        pulse_os_trig(0);
        wait_model(0, 0, 1, 1, 200);
        pulse_os_rearm(3'b001);
        check("rearm_busy",  64'(os_if.busy[0]), 64'd0);
        check("rearm_frame", 64'(os_if.frame_idx[FW-1:0]), 64'd0);
        os_if.trig[0] = 1'b1;
        pulse_os_rearm(3'b001);
        os_if.trig[0] = 1'b0;
        check("trig_rearm_busy", 64'(os_if.busy[0]), 64'd0);

        // Looping channel 1: wrap while held, drop trig during frame 2.
        lp_if.trig[1] = 1'b1;
        wait_model(1, 1, 3, 1, 300);
        wait_model(1, 1, 0, 1, 300);
        check("lp_wrap_busy", 64'(lp_if.busy[1]), 64'd1);
        wait_model(1, 1, 2, 1, 300);
        lp_if.trig[1] = 1'b0;
        wait_model(1, 1, 3, 1, 300);
        check("lp_drop_still_run", 64'(lp_if.busy[1]), 64'd1);
        wait_model(1, 1, 0, 0, 300);
        check("lp_drop_idle",  64'(lp_if.busy[1]), 64'd0);
        check("lp_drop_frame", 64'(lp_if.frame_idx[2*FW-1:FW]), 64'd0);

        // Trigger coinciding with a tick: that tick must not count.
        while ((ncyc % TICK_DIV) != TICK_DIV - 1) cycle();
        pulse_os_trig(2);
        check("s5_busy", 64'(os_if.busy[2]), 64'd1);
        n = 0;
        guard = 0;
        while (n < 15 && guard < 500) begin
            cycle();
            guard++;
            if (last_tk) begin
                n++;
                if (n == 14) check("s5_before_adv", 64'(os_if.frame_idx[3*FW-1:2*FW]), 64'd0);
            end
        end
        check("s5_first_adv", 64'(os_if.frame_idx[3*FW-1:2*FW]), 64'd1);

        // Staggered triggers on all channels.
        pulse_os_rearm('1);
        pulse_os_trig(0);
        repeat (7) cycle();
        pulse_os_trig(1);
        repeat (13) cycle();
        pulse_os_trig(2);
        repeat (150) cycle();

        // Randomized traffic on both instances, including ROM changes and resets.
        os_if.rearm = '1;
        lp_if.rearm = '1;
        cycle();
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 29) == 0) os_if.trig[ch] = ~os_if.trig[ch];
                if ($urandom_range(0, 29) == 0) lp_if.trig[ch] = ~lp_if.trig[ch];
                os_if.rearm[ch] = ($urandom_range(0, 199) == 0);
                lp_if.rearm[ch] = ($urandom_range(0, 199) == 0);
            end
            if ($urandom_range(0, 7) == 0) begin
                slot = $urandom_range(0, NCH*NFRAME - 1);
                os_if.rom_pix[slot*PIX_W +: PIX_W] = PIX_W'($urandom);
                lp_if.rom_pix[slot*PIX_W +: PIX_W] = PIX_W'($urandom);
            end
            rst_n = ($urandom_range(0, 999) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
